// File: rtl/missle_pkg.sv
// ============================================================================
// missle_pkg -- shared types and defaults for the missile launcher.
// Rev 1.0
// ============================================================================
`default_nettype none

package missle_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COOLDOWN = 3'd1,
    S_READY    = 3'd2,
    S_LAUNCH   = 3'd3,
    S_FLIGHT   = 3'd4
  } launcher_state_t;

  localparam logic [7:0]  DEF_COOLDOWN_FRAMES = 8'd90;
  localparam logic [7:0]  DEF_FLIGHT_TIMEOUT  = 8'd120;
  localparam logic [9:0]  DEF_LAUNCH_OFFSET_Y = 10'd12;
  localparam logic [9:0]  DEF_LAUNCH_OFFSET_X = 10'd0;
  localparam logic [9:0]  DEF_Y_LIMIT         = 10'd380;
  localparam logic [15:0] LFSR_SEED           = 16'hACE1;

  // Jittered cooldown needs one extra bit to hold 255 + 31.
`ifdef RANDOM_COOLDOWN_EN
  localparam int CNT_W = 9;
`else
  localparam int CNT_W = 8;
`endif

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16 -- 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on Reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr16
  import missle_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/missle_launcher.sv
// ============================================================================
// missle_launcher -- decides missile drops from the plane and sequences
// cooldown / flight; optional cooldown jitter via RANDOM_COOLDOWN_EN. Rev 1.0
// ============================================================================
`default_nettype none

module missle_launcher
  import missle_pkg::*;
#(
  parameter logic [7:0] COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter logic [7:0] FLIGHT_TIMEOUT  = DEF_FLIGHT_TIMEOUT,
  parameter logic [9:0] LAUNCH_OFFSET_Y = DEF_LAUNCH_OFFSET_Y,
  parameter logic [9:0] LAUNCH_OFFSET_X = DEF_LAUNCH_OFFSET_X,
  parameter logic [9:0] Y_LIMIT         = DEF_Y_LIMIT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic       auto_fire,
  input  logic       fire_req,
  input  logic [9:0] plane_x,
  input  logic [9:0] plane_y,
  input  logic       explored,
  output logic       launch,
  output logic [9:0] start_x,
  output logic [9:0] start_y,
  output logic       busy,
  output logic [7:0] shots
);

  launcher_state_t  r_state;
  launcher_state_t  w_next;

  logic             r_frame_q;
  logic             r_fe;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cd_load;
  logic [7:0]       r_fcnt;
  logic [7:0]       w_fcnt_nxt;
  logic             r_seen_low;
  logic             w_seen_low_nxt;
  logic             w_capture;
  logic [10:0]      w_sum_y;
  logic             w_y_ok;
  logic [9:0]       w_start_x;

  logic             r_launch;
  logic             r_busy;
  logic [9:0]       r_start_x;
  logic [9:0]       r_start_y;
  logic [7:0]       r_shots;

  assign w_sum_y   = {1'b0, plane_y} + {1'b0, LAUNCH_OFFSET_Y};
  assign w_y_ok    = (w_sum_y < {1'b0, Y_LIMIT});
  assign w_start_x = plane_x + LAUNCH_OFFSET_X;

`ifdef RANDOM_COOLDOWN_EN
  logic [15:0] w_lfsr_q;

  lfsr16 u_lfsr16 (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (w_lfsr_q)
  );

  assign w_cd_load = {1'b0, COOLDOWN_FRAMES} + {4'b0000, w_lfsr_q[4:0]};
`else
  assign w_cd_load = COOLDOWN_FRAMES;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Priority inside each state: enable=0, then explored, then timeout, then fire.
  always_comb begin
    w_next         = r_state;
    w_cnt_nxt      = r_cnt;
    w_fcnt_nxt     = r_fcnt;
    w_seen_low_nxt = r_seen_low;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next    = S_COOLDOWN;
          w_cnt_nxt = w_cd_load;
        end
      end
      S_COOLDOWN: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (r_fe) begin
          if (r_cnt == '0) begin
            w_next = S_READY;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      S_READY: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (r_fe && (auto_fire || fire_req) && w_y_ok) begin
          w_capture = 1'b1;
          w_next    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_seen_low_nxt = 1'b0;
        w_fcnt_nxt     = FLIGHT_TIMEOUT;
        w_next         = enable ? S_FLIGHT : S_IDLE;
      end
      S_FLIGHT: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if ((explored && r_seen_low) || (r_fe && (r_fcnt == 8'd0))) begin
          w_next    = S_COOLDOWN;
          w_cnt_nxt = w_cd_load;
        end else begin
          // A stale explored=1 must drop before it can end this flight.
          if (!explored) begin
            w_seen_low_nxt = 1'b1;
          end
          if (r_fe) begin
            w_fcnt_nxt = r_fcnt - 8'd1;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_q  <= 1'b0;
      r_fe       <= 1'b0;
      r_cnt      <= '0;
      r_fcnt     <= 8'd0;
      r_seen_low <= 1'b0;
      r_launch   <= 1'b0;
      r_busy     <= 1'b0;
      r_start_x  <= 10'd0;
      r_start_y  <= 10'd0;
      r_shots    <= 8'd0;
    end else begin
      r_frame_q  <= frame_clk;
      r_fe       <= frame_clk & ~r_frame_q;
      r_cnt      <= w_cnt_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_seen_low <= w_seen_low_nxt;
      r_launch   <= (w_next == S_LAUNCH);
      r_busy     <= (w_next == S_FLIGHT);
      if (w_capture) begin
        r_start_x <= w_start_x;
        r_start_y <= w_sum_y[9:0];
        r_shots   <= r_shots + 8'd1;
      end
    end
  end

  assign launch  = r_launch;
  assign busy    = r_busy;
  assign start_x = r_start_x;
  assign start_y = r_start_y;
  assign shots   = r_shots;

endmodule

`default_nettype wire

// File: tb/tb_missle_launcher.sv
// ============================================================================
// tb_missle_launcher -- scoreboard bench: launches checked against a queue of
// hand-computed captures, plus directed busy/reset checks. Rev 1.0
// ============================================================================
`default_nettype none

module tb_missle_launcher;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] shots;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       enable;
  logic       auto_fire;
  logic       fire_req;
  logic [9:0] plane_x;
  logic [9:0] plane_y;
  logic       explored;
  logic       launch;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       busy;
  logic [7:0] shots;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_exp[$];
  exp_t r_mon_e;

  missle_launcher #(
    .COOLDOWN_FRAMES (8'd3),
    .FLIGHT_TIMEOUT  (8'd4)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .enable    (enable),
    .auto_fire (auto_fire),
    .fire_req  (fire_req),
    .plane_x   (plane_x),
    .plane_y   (plane_y),
    .explored  (explored),
    .launch    (launch),
    .start_x   (start_x),
    .start_y   (start_y),
    .busy      (busy),
    .shots     (shots)
  );

  always #10 Clk = ~Clk;

  // Every launch strobe consumes exactly one expected capture.
  always @(negedge Clk) begin
    if (launch === 1'b1) begin
      n_checks++;
      if (q_exp.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_launch: got x=%0d y=%0d shots=%0d, required no launch",
                 start_x, start_y, shots);
      end else begin
        r_mon_e = q_exp.pop_front();
        if ({start_x, start_y, shots} !== r_mon_e) begin
          n_errors++;
          $display("FAIL launch_capture: got x=%0d y=%0d shots=%0d, required x=%0d y=%0d shots=%0d",
                   start_x, start_y, shots, r_mon_e.x, r_mon_e.y, r_mon_e.shots);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    tick(3);
    frame_clk = 1'b0;
    tick(3);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_launch(input logic [9:0] x, input logic [9:0] y, input logic [7:0] s);
    exp_t e;
    e.x = x;
    e.y = y;
    e.shots = s;
    q_exp.push_back(e);
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    enable    = 1'b0;
    auto_fire = 1'b0;
    fire_req  = 1'b0;
    plane_x   = 10'd0;
    plane_y   = 10'd0;
    explored  = 1'b0;
    tick(3);
    check("reset_launch", 32'(launch), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_start_x", 32'(start_x), 32'd0);
    check("reset_start_y", 32'(start_y), 32'd0);
    check("reset_shots", 32'(shots), 32'd0);
    Reset = 1'b0;

    // Normal launch with a stale explored held high through the launch.
    plane_x   = 10'd100;
    plane_y   = 10'd50;
    auto_fire = 1'b1;
    explored  = 1'b1;
    enable    = 1'b1;
    tick(2);
    frames(4);
    check("no_busy_in_ready", 32'(busy), 32'd0);
    expect_launch(10'd100, 10'd62, 8'd1);
    frame();
    check("busy_after_launch", 32'(busy), 32'd1);
    tick(4);
    check("stale_explored_ignored", 32'(busy), 32'd1);
    explored = 1'b0;
    tick(5);
    check("busy_while_explored_low", 32'(busy), 32'd1);
    explored = 1'b1;
    check("busy_before_explored_edge", 32'(busy), 32'd1);
    tick(1);
    check("busy_drop_on_explored", 32'(busy), 32'd0);

    // Y limit: 370+12 and 368+12 both blocked, 360+12 launches.
    explored = 1'b0;
    plane_x  = 10'd517;
    plane_y  = 10'd370;
    frames(14);
    plane_y  = 10'd368;
    frames(2);
    check("no_launch_at_y_limit", 32'(shots), 32'd1);
    plane_y  = 10'd360;
    expect_launch(10'd517, 10'd372, 8'd2);
    frame();
    check("busy_after_y_launch", 32'(busy), 32'd1);

    // Flight timeout with explored stuck low.
    frames(4);
    check("busy_before_timeout", 32'(busy), 32'd1);
    frame();
    check("busy_after_timeout", 32'(busy), 32'd0);
    frames(4);
    expect_launch(10'd517, 10'd372, 8'd3);
    frame();
    check("busy_after_relaunch", 32'(busy), 32'd1);

    // Abort mid-cooldown; re-enable must reload the full cooldown.
    explored = 1'b1;
    tick(2);
    check("cooldown_after_explored", 32'(busy), 32'd0);
    frames(2);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    frames(4);
    expect_launch(10'd517, 10'd372, 8'd4);
    frame();
    check("busy_after_reenable_launch", 32'(busy), 32'd1);
    check("shots_after_four", 32'(shots), 32'd4);

    // Reset while in flight.
    Reset = 1'b1;
    tick(1);
    check("flight_reset_launch", 32'(launch), 32'd0);
    check("flight_reset_busy", 32'(busy), 32'd0);
    check("flight_reset_start_x", 32'(start_x), 32'd0);
    check("flight_reset_start_y", 32'(start_y), 32'd0);
    check("flight_reset_shots", 32'(shots), 32'd0);
    Reset = 1'b0;

    // 256 launches wrap the shot counter back to zero.
    tick(2);
    for (int i = 1; i <= 256; i++) begin
      plane_x = 10'(i * 3);
      plane_y = 10'(i % 300);
      frames(4);
      expect_launch(10'(i * 3), 10'((i % 300) + 12), 8'(i));
      frame();
      explored = 1'b0;
      tick(1);
      explored = 1'b1;
      tick(2);
    end
    check("shots_wrapped", 32'(shots), 32'd0);
    check("busy_after_wrap", 32'(busy), 32'd0);

    tick(4);
    check("all_launches_seen", 32'(q_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
